operand_fetch: RTL and testbench
================================

# operand_fetch

Register file plus operand-latch stage directly upstream of the ALU in the multicycle datapath. Holds the 32×32-bit general registers and extends the 16-bit instruction immediate. Latches the two ALU operands into the A and B registers, which drive the ALU's `A` and `B` inputs for the following execute cycle. Write-back data from the downstream stages returns through the write port.

## Interface
Parameters:
- `ZERO_REG`, default 1. When 1, R0 reads 0 and writes to it are discarded. When 0, R0 is an ordinary register.

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Rst_n` in 1: reset, synchronous, active-low.
- `Ard1` in 5: read address, port 1; feeds the A path.
- `Ard2` in 5: read address, port 2; feeds the B path when `BSel`=0.
- `Awr` in 5: write address.
- `Din` in 32: write data.
- `WrEn` in 1: write enable.
- `Immed` in 16: instruction immediate field.
- `ImmExt` in 2: extension mode.
  - 00: zero-extend.
  - 01: sign-extend.
  - 10: `{Immed,16'h0}`.
  - 11: sign-extend then shift left by 2.
- `BSel` in 1: B source. 0 selects port-2 data; 1 selects the extended immediate.
- `OpLoad` in 1: capture operands into A/B this edge.
- `Dout1` out 32: combinational port-1 read data, after bypass.
- `Dout2` out 32: combinational port-2 read data, after bypass.
- `ImmOut` out 32: combinational extended immediate.
- `A_out` out 32: registered ALU operand A.
- `B_out` out 32: registered ALU operand B.
- `OpValid` out 1: registered; high for exactly the cycle after an accepted `OpLoad`.

## Operation
- **Register array:** 32 entries × 32 bits.
- **Write:**
  - Occurs at the edge when `Rst_n`=1 and `WrEn`=1.
  - When `Awr`=0 and `ZERO_REG`=1, the write is dropped.
- **Read (combinational):**
  - `DoutN` = `Din` if `WrEn`=1, `Awr`=`ArdN`, and the write is not dropped (write-through bypass).
  - Otherwise `DoutN` = the stored entry.
  - When `ArdN`=0 and `ZERO_REG`=1, `DoutN` = 0 regardless of bypass.
- **Immediate extension:** purely combinational. Mode 11 is `{{14{Immed[15]}},Immed,2'b00}`.
- **Operand latch:** at an edge with `Rst_n`=1 and `OpLoad`=1:
  - `A_out` ← `Dout1`.
  - `B_out` ← (`BSel` ? `ImmOut` : `Dout2`).
  - `OpValid` ← 1.
- **Operand hold:** at an edge with `OpLoad`=0, A/B hold their value and `OpValid` ← 0.
- **Simultaneous events:**
  - A write and an `OpLoad` in the same cycle are both performed.
  - If the load reads the address being written, it captures `Din`, via the bypass.
  - Both read ports may address the same register; both see identical data.

## Timing
- **Reset (`Rst_n`=0 at an edge):**
  - All 32 registers ← 0; `A_out`, `B_out` ← 0; `OpValid` ← 0.
  - Writes and loads presented in that cycle are ignored.
  - Reset has priority over `WrEn` and `OpLoad`.
  - Deasserting reset mid-sequence loses any pending operand; nothing is replayed.
- **Latencies:**
  - Write: visible on `DoutN` in the same cycle (bypass) and stored from the next cycle on.
  - `OpLoad` → `A_out`/`B_out`/`OpValid`: 1 cycle.
  - `Dout`/`ImmOut`: 0-cycle combinational.
- **Back-to-back `OpLoad`:** accepted every cycle; `OpValid` then stays high continuously.
- **Idle behaviour:** no handshake back-pressure. The stage never stalls; the controller sequences `OpLoad`.

## Test plan
- **Reset:** write R5=0xDEADBEEF, then assert `Rst_n`=0 for 1 edge. Required: `Dout1`(Ard1=5)=0, `A_out`=`B_out`=0, `OpValid`=0. A write presented during reset is not stored.
- **R0 protection:** write 0xFFFFFFFF to R0 with `ZERO_REG`=1. Required: `Dout1`/`Dout2` at address 0 read 0 in the same cycle and afterwards.
- **Bypass plus load:** with R7=0x11, present `WrEn`=1, `Awr`=7, `Din`=0x22, `Ard1`=7, `OpLoad`=1, `BSel`=0, `Ard2`=7. Required: `A_out`=`B_out`=0x22 and `OpValid`=1 the next cycle; `Dout1`=0x22 on the next read.
- **Immediate modes:** `Immed`=0x8004 with `BSel`=1 and `OpLoad`=1. Required `B_out` per mode:
  - mode 00: 0x00008004
  - mode 01: 0xFFFF8004
  - mode 10: 0x80040000
  - mode 11: 0xFFFE0010
- **Hold and valid pulse:** `OpLoad` high for cycles 1–2, then low. Required: `OpValid` high in cycles 2–3 only; `A_out`/`B_out` unchanged after cycle 3 despite changes on `Ard1`/`Ard2`/`WrEn`.
- **Full array:** write R1..R31 with value `i×0x01010101`, then read every pair (i, 31−i). Required: exact stored values on both ports and no aliasing.

Source files
------------

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: register-file ports, immediate controls and latched ALU operands
interface operand_fetch_if;
  logic [4:0]  Ard1;
  logic [4:0]  Ard2;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [15:0] Immed;
  logic [1:0]  ImmExt;
  logic        BSel;
  logic        OpLoad;
  logic [31:0] Dout1;
  logic [31:0] Dout2;
  logic [31:0] ImmOut;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic        OpValid;
  modport master (
    output Ard1, Ard2, Awr, Din, WrEn, Immed, ImmExt, BSel, OpLoad,
    input  Dout1, Dout2, ImmOut, A_out, B_out, OpValid
  );
  modport slave (
    input  Ard1, Ard2, Awr, Din, WrEn, Immed, ImmExt, BSel, OpLoad,
    output Dout1, Dout2, ImmOut, A_out, B_out, OpValid
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: 32x32 register file with write-through bypass, immediate extender and A/B operand latch
module operand_fetch #(
  parameter bit ZERO_REG = 1'b1
) (
  input logic            Clk,
  input logic            Rst_n,
  operand_fetch_if.slave bus
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        valid_q, valid_d;
  logic        wr_ok;
  logic [31:0] dout1, dout2, imm;
  // A write to R0 is discarded when R0 is hardwired, so it must not bypass either
  assign wr_ok = bus.WrEn && !(ZERO_REG && bus.Awr == 5'd0);
  always_comb begin
    dout1 = (ZERO_REG && bus.Ard1 == 5'd0) ? 32'd0
          : (wr_ok && bus.Awr == bus.Ard1) ? bus.Din : regs_q[bus.Ard1];
    dout2 = (ZERO_REG && bus.Ard2 == 5'd0) ? 32'd0
          : (wr_ok && bus.Awr == bus.Ard2) ? bus.Din : regs_q[bus.Ard2];
    imm   = bus.ImmExt == 2'b00 ? {16'h0, bus.Immed}
          : bus.ImmExt == 2'b01 ? {{16{bus.Immed[15]}}, bus.Immed}
          : bus.ImmExt == 2'b10 ? {bus.Immed, 16'h0}
          : {{14{bus.Immed[15]}}, bus.Immed, 2'b00};
  end
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.Awr] = bus.Din;
    a_d     = bus.OpLoad ? dout1 : a_q;
    b_d     = bus.OpLoad ? (bus.BSel ? imm : dout2) : b_q;
    valid_d = bus.OpLoad;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end
  assign bus.Dout1   = dout1;
  assign bus.Dout2   = dout2;
  assign bus.ImmOut  = imm;
  assign bus.A_out   = a_q;
  assign bus.B_out   = b_q;
  assign bus.OpValid = valid_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors for operand_fetch with hand-computed expectations
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  operand_fetch_if bus();
  operand_fetch #(.ZERO_REG(1'b1)) dut (.Clk(clk), .Rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.WrEn = 0; bus.OpLoad = 0; bus.BSel = 0;
    bus.Awr = 0; bus.Din = 0; bus.Ard1 = 0; bus.Ard2 = 0;
    bus.Immed = 0; bus.ImmExt = 0;
  endtask
  task automatic test_reset();
    rst_n = 1; idle();
    bus.WrEn = 1; bus.Awr = 5; bus.Din = 32'hDEADBEEF;
    step();
    bus.WrEn = 0; bus.Ard1 = 5; bus.Ard2 = 5; bus.OpLoad = 1;
    step();
    n_vec++;
    if (bus.A_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL reset_preload A_out got %h want %h", bus.A_out, 32'hDEADBEEF); end
    rst_n = 0; bus.WrEn = 1; bus.Awr = 6; bus.Din = 32'h1234; bus.OpLoad = 1;
    step();
    rst_n = 1; bus.WrEn = 0; bus.OpLoad = 0; bus.Ard1 = 5; bus.Ard2 = 6;
    #1;
    n_vec++;
    if (bus.Dout1 !== 32'd0) begin n_err++; $display("FAIL reset_r5 Dout1 got %h want 0", bus.Dout1); end
    n_vec++;
    if (bus.Dout2 !== 32'd0) begin n_err++; $display("FAIL reset_write_ignored Dout2 got %h want 0", bus.Dout2); end
    n_vec++;
    if (bus.A_out !== 32'd0 || bus.B_out !== 32'd0) begin n_err++; $display("FAIL reset_ab A_out %h B_out %h want 0", bus.A_out, bus.B_out); end
    n_vec++;
    if (bus.OpValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.OpValid); end
  endtask
  task automatic test_r0();
    idle();
    bus.WrEn = 1; bus.Awr = 0; bus.Din = 32'hFFFFFFFF;
    #1;
    n_vec++;
    if (bus.Dout1 !== 32'd0 || bus.Dout2 !== 32'd0) begin n_err++; $display("FAIL r0_same_cycle Dout1 %h Dout2 %h want 0", bus.Dout1, bus.Dout2); end
    step();
    bus.WrEn = 0;
    #1;
    n_vec++;
    if (bus.Dout1 !== 32'd0 || bus.Dout2 !== 32'd0) begin n_err++; $display("FAIL r0_after Dout1 %h Dout2 %h want 0", bus.Dout1, bus.Dout2); end
  endtask
  task automatic test_bypass_load();
    idle();
    bus.WrEn = 1; bus.Awr = 7; bus.Din = 32'h11;
    step();
    bus.Din = 32'h22; bus.Ard1 = 7; bus.Ard2 = 7; bus.OpLoad = 1; bus.BSel = 0;
    #1;
    n_vec++;
    if (bus.Dout1 !== 32'h22 || bus.Dout2 !== 32'h22) begin n_err++; $display("FAIL bypass_comb Dout1 %h Dout2 %h want 22", bus.Dout1, bus.Dout2); end
    step();
    bus.WrEn = 0; bus.OpLoad = 0;
    #1;
    n_vec++;
    if (bus.A_out !== 32'h22 || bus.B_out !== 32'h22) begin n_err++; $display("FAIL bypass_load A_out %h B_out %h want 22", bus.A_out, bus.B_out); end
    n_vec++;
    if (bus.OpValid !== 1'b1) begin n_err++; $display("FAIL bypass_valid got %b want 1", bus.OpValid); end
    n_vec++;
    if (bus.Dout1 !== 32'h22) begin n_err++; $display("FAIL bypass_stored Dout1 got %h want 22", bus.Dout1); end
  endtask
  task automatic test_imm();
    logic [31:0] exp_imm [4];
    exp_imm[0] = 32'h00008004; exp_imm[1] = 32'hFFFF8004;
    exp_imm[2] = 32'h80040000; exp_imm[3] = 32'hFFFE0010;
    idle();
    for (int m = 0; m < 4; m++) begin
      bus.Immed = 16'h8004; bus.ImmExt = 2'(m); bus.BSel = 1; bus.OpLoad = 1;
      #1;
      n_vec++;
      if (bus.ImmOut !== exp_imm[m]) begin n_err++; $display("FAIL imm_comb mode %0d got %h want %h", m, bus.ImmOut, exp_imm[m]); end
      step();
      n_vec++;
      if (bus.B_out !== exp_imm[m]) begin n_err++; $display("FAIL imm_load mode %0d B_out got %h want %h", m, bus.B_out, exp_imm[m]); end
    end
    idle();
  endtask
  task automatic test_hold();
    idle();
    bus.WrEn = 1; bus.Awr = 3; bus.Din = 32'h33;
    step();
    bus.Awr = 4; bus.Din = 32'h44;
    step();
    bus.WrEn = 0;
    bus.OpLoad = 1; bus.Ard1 = 3; bus.Ard2 = 4;
    step();
    n_vec++;
    if (bus.OpValid !== 1'b1 || bus.A_out !== 32'h33 || bus.B_out !== 32'h44) begin n_err++; $display("FAIL hold_c2 valid %b A %h B %h want 1 33 44", bus.OpValid, bus.A_out, bus.B_out); end
    bus.Ard1 = 4; bus.Ard2 = 3;
    step();
    n_vec++;
    if (bus.OpValid !== 1'b1 || bus.A_out !== 32'h44 || bus.B_out !== 32'h33) begin n_err++; $display("FAIL hold_c3 valid %b A %h B %h want 1 44 33", bus.OpValid, bus.A_out, bus.B_out); end
    bus.OpLoad = 0; bus.Ard1 = 9; bus.Ard2 = 10; bus.WrEn = 1; bus.Awr = 4; bus.Din = 32'h99;
    step();
    n_vec++;
    if (bus.OpValid !== 1'b0 || bus.A_out !== 32'h44 || bus.B_out !== 32'h33) begin n_err++; $display("FAIL hold_c4 valid %b A %h B %h want 0 44 33", bus.OpValid, bus.A_out, bus.B_out); end
    bus.WrEn = 0; bus.Ard1 = 4;
    step();
    n_vec++;
    if (bus.OpValid !== 1'b0 || bus.A_out !== 32'h44 || bus.B_out !== 32'h33) begin n_err++; $display("FAIL hold_c5 valid %b A %h B %h want 0 44 33", bus.OpValid, bus.A_out, bus.B_out); end
  endtask
  task automatic test_full_array();
    logic [31:0] e1, e2;
    idle();
    for (int i = 1; i < 32; i++) begin
      bus.WrEn = 1; bus.Awr = 5'(i); bus.Din = i * 32'h01010101;
      step();
    end
    bus.WrEn = 0;
    for (int i = 0; i < 32; i++) begin
      bus.Ard1 = 5'(i); bus.Ard2 = 5'(31 - i);
      #1;
      e1 = i * 32'h01010101;
      e2 = (31 - i) * 32'h01010101;
      n_vec++;
      if (bus.Dout1 !== e1) begin n_err++; $display("FAIL array_p1 addr %0d got %h want %h", i, bus.Dout1, e1); end
      n_vec++;
      if (bus.Dout2 !== e2) begin n_err++; $display("FAIL array_p2 addr %0d got %h want %h", 31 - i, bus.Dout2, e2); end
    end
  endtask
  task automatic test_back_to_back();
    idle();
    bus.OpLoad = 1; bus.BSel = 0;
    for (int i = 1; i < 5; i++) begin
      bus.Ard1 = 5'(i); bus.Ard2 = 5'(i);
      step();
      n_vec++;
      if (bus.OpValid !== 1'b1 || bus.A_out !== i * 32'h01010101 || bus.B_out !== i * 32'h01010101) begin
        n_err++; $display("FAIL b2b load %0d valid %b A %h B %h want 1 %h", i, bus.OpValid, bus.A_out, bus.B_out, i * 32'h01010101);
      end
    end
    idle();
  endtask
  initial begin
    idle();
    rst_n = 0;
    step();
    test_reset();
    test_r0();
    test_bypass_load();
    test_imm();
    test_hold();
    test_full_array();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
